// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and small types used by the register file.
package cpu_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  // Writeback strobe plus destination; data travels beside it so XLEN stays a module parameter.
  typedef struct packed {
    logic      en;
    reg_addr_t addr;
  } wb_req_t;

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: register mux, writeback bypass, pending lookup, output flops.
module register_file_read_port
  import cpu_pkg::reg_addr_t;
  import cpu_pkg::wb_req_t;
#(
  parameter int XLEN     = cpu_pkg::XLEN,
  parameter int NUM_REGS = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           read_enable,
  input  reg_addr_t                      read_addr,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  regs,
  input  logic [NUM_REGS-1:0]            pend_nxt,
  input  wb_req_t                        wb_req,
  input  logic [XLEN-1:0]                wb_data,
  output logic [XLEN-1:0]                read_data,
  output logic                           read_pending
);

  logic [XLEN-1:0] data_sel;
  logic            pend_sel;

  // Select the value the register will hold after this edge: x0 is zero, a same-cycle write wins.
  always_comb begin
    data_sel = regs[read_addr];
    pend_sel = pend_nxt[read_addr];
    if (read_addr == '0) begin
      data_sel = '0;
      pend_sel = 1'b0;
    end else if (wb_req.en && (wb_req.addr == read_addr)) begin
      data_sel = wb_data;
    end
  end

  // Output register: loads only when a read is issued, otherwise holds the last result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data    <= '0;
      read_pending <= 1'b0;
    end else if (read_enable) begin
      read_data    <= data_sel;
      read_pending <= pend_sel;
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with per-register writeback-pending scoreboard.
module register_file
  import cpu_pkg::reg_addr_t;
  import cpu_pkg::wb_req_t;
#(
  parameter int XLEN     = cpu_pkg::XLEN,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            read_enable,
  input  reg_addr_t       read_addr1,
  input  reg_addr_t       read_addr2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            read_pending1,
  output logic            read_pending2,
  input  logic            pending_set_enable,
  input  reg_addr_t       pending_set_addr,
  input  logic            write_enable,
  input  reg_addr_t       write_addr,
  input  logic [XLEN-1:0] write_data
);

  localparam int NUM_RD = 2;

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
  logic [NUM_REGS-1:0]           pend_q;
  logic [NUM_REGS-1:0]           pend_nxt;
  wb_req_t                       wb_req;

  reg_addr_t [NUM_RD-1:0]            rd_addr;
  logic      [NUM_RD-1:0][XLEN-1:0]  rd_data;
  logic      [NUM_RD-1:0]            rd_pend;

  assign wb_req = '{en: write_enable, addr: write_addr};

  // Next pending state: writeback clears, issue sets afterwards so a newer producer wins; x0 never pends.
  always_comb begin
    pend_nxt = pend_q;
    if (write_enable)       pend_nxt[write_addr]       = 1'b0;
    if (pending_set_enable) pend_nxt[pending_set_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Pending scoreboard state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= '0;
    else          pend_q <= pend_nxt;
  end

  // Register storage; x0 is never written so it stays zero from reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
    end else if (write_enable && (write_addr != '0)) begin
      regs_q[write_addr] <= write_data;
    end
  end

  assign rd_addr[0] = read_addr1;
  assign rd_addr[1] = read_addr2;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    register_file_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS)
    ) u_rd (
      .clk          (clk),
      .reset_n      (reset_n),
      .read_enable  (read_enable),
      .read_addr    (rd_addr[p]),
      .regs         (regs_q),
      .pend_nxt     (pend_nxt),
      .wb_req       (wb_req),
      .wb_data      (write_data),
      .read_data    (rd_data[p]),
      .read_pending (rd_pend[p])
    );
  end

  assign read_data1    = rd_data[0];
  assign read_data2    = rd_data[1];
  assign read_pending1 = rd_pend[0];
  assign read_pending2 = rd_pend[1];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, reset corner sequences, randomized model check.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_enable;
  logic [4:0]  read_addr1, read_addr2;
  logic [31:0] read_data1, read_data2;
  logic        read_pending1, read_pending2;
  logic        pending_set_enable;
  logic [4:0]  pending_set_addr;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  int tests  = 0;
  int failed = 0;

  register_file dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .read_enable        (read_enable),
    .read_addr1         (read_addr1),
    .read_addr2         (read_addr2),
    .read_data1         (read_data1),
    .read_data2         (read_data2),
    .read_pending1      (read_pending1),
    .read_pending2      (read_pending2),
    .pending_set_enable (pending_set_enable),
    .pending_set_addr   (pending_set_addr),
    .write_enable       (write_enable),
    .write_addr         (write_addr),
    .write_data         (write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic [4:0]  ra1, ra2;
    logic        pse;
    logic [4:0]  psa;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_d1, e_d2;
    logic        e_p1, e_p2;
  } vec_t;

  vec_t vecs[14];

  // Behavioural model state for the random phase.
  logic [31:0] m_mem  [32];
  logic        m_pend [32];
  logic [31:0] m_d1, m_d2;
  logic        m_p1, m_p2;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic re, logic [4:0] ra1, logic [4:0] ra2, logic pse, logic [4:0] psa,
                       logic we, logic [4:0] wa, logic [31:0] wd);
    read_enable = re; read_addr1 = ra1; read_addr2 = ra2;
    pending_set_enable = pse; pending_set_addr = psa;
    write_enable = we; write_addr = wa; write_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic chk(string name, logic [31:0] e_d1, logic [31:0] e_d2, logic e_p1, logic e_p2);
    tests++;
    if (read_data1 !== e_d1 || read_data2 !== e_d2 || read_pending1 !== e_p1 || read_pending2 !== e_p2) begin
      failed++;
      $display("FAIL %s: got d1=%h d2=%h p1=%b p2=%b, expected d1=%h d2=%h p1=%b p2=%b",
               name, read_data1, read_data2, read_pending1, read_pending2, e_d1, e_d2, e_p1, e_p2);
    end
  endtask

  function automatic vec_t mk(logic re, logic [4:0] ra1, logic [4:0] ra2, logic pse, logic [4:0] psa,
                              logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [31:0] d1, logic [31:0] d2, logic p1, logic p2);
    vec_t v;
    v.re = re; v.ra1 = ra1; v.ra2 = ra2; v.pse = pse; v.psa = psa;
    v.we = we; v.wa = wa; v.wd = wd;
    v.e_d1 = d1; v.e_d2 = d2; v.e_p1 = p1; v.e_p2 = p2;
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    // Each row is one clock: inputs applied before the edge, outputs expected after it.
    //            re  ra1   ra2   pse psa   we  wa    wd            d1            d2            p1 p2
    vecs[0]  = mk(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0);
    vecs[1]  = mk(1, 5'd5, 5'd0, 0, 5'd0, 0, 5'd0, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0);
    vecs[2]  = mk(1, 5'd0, 5'd0, 0, 5'd0, 1, 5'd0, 32'h12345678, 32'h0,        32'h0,        0, 0);
    vecs[3]  = mk(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd7, 32'h1,        32'h0,        32'h0,        0, 0);
    vecs[4]  = mk(1, 5'd0, 5'd7, 0, 5'd0, 1, 5'd7, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 0, 0);
    vecs[5]  = mk(0, 5'd0, 5'd0, 1, 5'd3, 0, 5'd0, 32'h0,        32'h0,        32'hA5A5A5A5, 0, 0);
    vecs[6]  = mk(1, 5'd3, 5'd7, 0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        32'hA5A5A5A5, 1, 0);
    vecs[7]  = mk(1, 5'd3, 5'd3, 0, 5'd0, 1, 5'd3, 32'h55,       32'h55,       32'h55,       0, 0);
    vecs[8]  = mk(1, 5'd9, 5'd9, 1, 5'd9, 1, 5'd9, 32'hCAFE,     32'hCAFE,     32'hCAFE,     1, 1);
    vecs[9]  = mk(1, 5'd9, 5'd0, 0, 5'd0, 0, 5'd0, 32'h0,        32'hCAFE,     32'h0,        1, 0);
    vecs[10] = mk(1, 5'd0, 5'd9, 1, 5'd0, 0, 5'd0, 32'h0,        32'h0,        32'hCAFE,     0, 1);
    vecs[11] = mk(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd4, 32'h77,       32'h0,        32'hCAFE,     0, 1);
    vecs[12] = mk(1, 5'd4, 5'd4, 0, 5'd0, 0, 5'd0, 32'h0,        32'h77,       32'h77,       0, 0);
    vecs[13] = mk(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd4, 32'h99,       32'h77,       32'h77,       0, 0);

    do_reset();
    chk("reset_state", 32'h0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].re, vecs[i].ra1, vecs[i].ra2, vecs[i].pse, vecs[i].psa,
            vecs[i].we, vecs[i].wa, vecs[i].wd);
      cyc();
      chk($sformatf("vec%0d", i), vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_p1, vecs[i].e_p2);
    end

    // Asynchronous reset mid-cycle: outputs must clear with no clock edge.
    idle();
    #3 reset_n = 1'b0;
    #1 chk("async_reset_no_edge", 32'h0, 32'h0, 1'b0, 1'b0);
    // Strobes across an edge held in reset must be discarded.
    drive(1'b1, 5'd12, 5'd9, 1'b1, 5'd12, 1'b1, 5'd12, 32'h1234);
    cyc();
    chk("strobes_in_reset", 32'h0, 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    drive(1'b1, 5'd4, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    cyc();
    chk("regs_cleared_by_reset", 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 5'd12, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    cyc();
    chk("write_in_reset_dropped", 32'h0, 32'h0, 1'b0, 1'b0);

    // Randomized phase against a rule-level model.
    do_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = 32'h0;
      m_pend[r] = 1'b0;
    end
    m_d1 = 32'h0; m_d2 = 32'h0; m_p1 = 1'b0; m_p2 = 1'b0;

    for (int n = 0; n < 400; n++) begin
      logic        re, pse, we;
      logic [4:0]  ra1, ra2, psa, wa;
      logic [31:0] wd;
      logic        np [32];
      re  = ($urandom_range(0, 3) != 0);
      ra1 = 5'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 7));
      pse = ($urandom_range(0, 2) == 0);
      psa = 5'($urandom_range(0, 7));
      we  = ($urandom_range(0, 1) == 1);
      wa  = ($urandom_range(0, 2) == 0) ? ra1 : 5'($urandom_range(0, 7));
      wd  = $urandom;
      drive(re, ra1, ra2, pse, psa, we, wa, wd);

      // Pending after this edge: writeback retires, a new issue to the same register re-marks it.
      for (int r = 0; r < 32; r++) np[r] = m_pend[r];
      if (we) np[wa] = 1'b0;
      if (pse) np[psa] = 1'b1;
      np[0] = 1'b0;
      if (re) begin
        m_d1 = (ra1 == 0) ? 32'h0 : ((we && wa == ra1) ? wd : m_mem[ra1]);
        m_d2 = (ra2 == 0) ? 32'h0 : ((we && wa == ra2) ? wd : m_mem[ra2]);
        m_p1 = np[ra1];
        m_p2 = np[ra2];
      end
      if (we && wa != 0) m_mem[wa] = wd;
      for (int r = 0; r < 32; r++) m_pend[r] = np[r];

      cyc();
      chk($sformatf("rand%0d", n), m_d1, m_d2, m_p1, m_p2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, register/data width.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count; address width = $clog2(NUM_REGS) = 5.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low, synchronous deassert by system.
REQ-005 SHALL have port read_enable  input  1  capture read addresses this cycle; low = hold read outputs.
REQ-006 SHALL have port read_addr1  input  5  read port 1 address (rs1).
REQ-007 SHALL have port read_addr2  input  5  read port 2 address (rs2).
REQ-008 SHALL have port read_data1  output  32  registered value of read_addr1.
REQ-009 SHALL have port read_data2  output  32  registered value of read_addr2.
REQ-010 SHALL have port read_pending1  output  1  registered pending flag for read_addr1.
REQ-011 SHALL have port read_pending2  output  1  registered pending flag for read_addr2.
REQ-012 SHALL have port pending_set_enable  input  1  issue stage marks a destination as awaiting writeback.
REQ-013 SHALL have port pending_set_addr  input  5  destination register being marked.
REQ-014 SHALL have port write_enable  input  1  writeback write strobe (register_file_write_enable).
REQ-015 SHALL have port write_addr  input  5  writeback destination (register_file_write_addr).
REQ-016 SHALL have port write_data  input  32  writeback value (register_file_write_data).

Function
REQ-017 SHALL store NUM_REGS x XLEN entries; x0 reads 0 always; writes to x0 ignored.
REQ-018 SHALL commit write_data to write_addr on the edge where write_enable=1; no handshake, always accepted.
REQ-019 SHALL, when read_enable=1, load read_dataN on the next edge: 1-cycle read latency.
REQ-020 SHALL bypass: same-cycle write_enable with write_addr==read_addrN (non-zero) loads write_data into read_dataN, not the stale entry.
REQ-021 SHALL, when read_enable=0, hold read_dataN and read_pendingN unchanged regardless of writes.
REQ-022 SHALL keep one pending bit per register; pending_set_enable sets bit[pending_set_addr]; write_enable clears bit[write_addr].
REQ-023 SHALL, on simultaneous set and clear of the same address, leave the bit set (newer producer wins).
REQ-024 SHALL never set pending for x0; read_pendingN for x0 always 0.
REQ-025 SHALL load read_pendingN with the post-update (next-state) pending bit, consistent with REQ-020/023.
REQ-026 SHALL let both read ports address the same register and return identical results.

Reset
REQ-027 SHALL, while reset_n=0, clear all entries, all pending bits, read_data1/2=0, read_pending1/2=0 immediately.
REQ-028 SHALL ignore write/set strobes on any edge where reset_n=0; reset mid-operation discards in-flight writes.

Structure
REQ-029 SHALL take XLEN and REG_ADDR_WIDTH from shared package cpu_pkg, which also defines reg_addr_t.
REQ-030 SHALL implement each read port (mux, bypass, pending lookup, output register) as sub-module register_file_read_port, instantiated twice.

Verification
REQ-031 Reset, write x5=0xDEADBEEF, next cycle read rs1=5 -> read_data1=0xDEADBEEF one cycle later, pending1=0.
REQ-032 Write x0=0x12345678 with read rs1=0, rs2=0 -> read_data1=read_data2=0.
REQ-033 Same-cycle write x7=0xA5A5A5A5 and read rs2=7 (x7 previously 0x1) -> read_data2=0xA5A5A5A5.
REQ-034 Set pending x3; next cycle read rs1=3 -> pending1=1; then write x3=0x55 with read rs1=3 -> data 0x55, pending1=0.
REQ-035 Same-cycle set and clear x9 -> subsequent read of x9 shows pending=1 and written data.
REQ-036 Read x4=0x77 then read_enable=0 while writing x4=0x99 -> read_data1 stays 0x77; assert reset_n=0 mid-sequence -> all outputs 0 without clock edge.
